// File: rtl/relu_maxpool.sv
// relu_maxpool: requantize (arithmetic shift), ReLU with unsigned saturation,
// and 2x2 stride-2 pooling over a raster-ordered accumulator stream.
// Pooled pixels leave through a single-entry valid/ready output register.
// Build option: define POOL_AVG_EN for floor-average pooling instead of max.
// Assumes ACC_WIDTH > DATA_WIDTH and an even MAP_WIDTH/MAP_HEIGHT >= 2.
module relu_maxpool #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int MAP_WIDTH  = 8,
  parameter int MAP_HEIGHT = 8,
  parameter int SHIFT      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ACC_WIDTH-1:0]  i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int NPIX     = MAP_WIDTH * MAP_HEIGHT;
  localparam int NOUT     = NPIX / 4;
  localparam int CW       = $clog2(MAP_WIDTH);
  localparam int RW       = $clog2(MAP_HEIGHT);
  localparam int IW       = $clog2(NPIX + 1);
  localparam int OW       = $clog2(NOUT + 1);
  localparam int LB_DEPTH = MAP_WIDTH / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int PIX_MAX  = (2 ** DATA_WIDTH) - 1;
`ifdef POOL_AVG_EN
  localparam int LBDW     = DATA_WIDTH + 1;
`else
  localparam int LBDW     = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [IW-1:0]          in_cnt;
  logic [OW-1:0]          out_cnt;
  logic [DATA_WIDTH-1:0]  h;
  logic [DATA_WIDTH-1:0]  pix;
  logic signed [ACC_WIDTH-1:0] q;
  logic [LBDW-1:0]        line_buf [LB_DEPTH];
  logic [LBW-1:0]         lb_idx;
  logic [LBDW-1:0]        pair;
  logic [DATA_WIDTH-1:0]  pooled;
`ifdef POOL_AVG_EN
  logic [DATA_WIDTH+1:0]  total;
`endif
  logic                   xfer;
  logic                   produce;
  logic                   accept;
  logic                   last_out;

  assign xfer     = i_valid && o_ready;
  assign produce  = xfer && col[0] && row[0];
  assign accept   = o_valid && i_ready;
  assign last_out = (out_cnt == OW'(NOUT - 1));
  assign lb_idx   = LBW'(col >> 1);

  // Requantize the accumulator and clamp into the unsigned pixel range.
  always_comb begin
    q = $signed(i_data) >>> SHIFT;
    if (q[ACC_WIDTH-1]) begin
      pix = '0;
    end else if ($unsigned(q) > ACC_WIDTH'(PIX_MAX)) begin
      pix = '1;
    end else begin
      pix = q[DATA_WIDTH-1:0];
    end
  end

`ifdef POOL_AVG_EN
  // Pair sum for the odd column, then floor of the four-pixel mean.
  always_comb begin
    pair   = {1'b0, h} + {1'b0, pix};
    total  = {1'b0, line_buf[lb_idx]} + {1'b0, pair};
    pooled = total[DATA_WIDTH+1:2];
  end
`else
  // Horizontal max for the odd column, then vertical max against the line buffer.
  always_comb begin
    pair   = (pix > h) ? pix : h;
    pooled = (line_buf[lb_idx] > pair) ? line_buf[lb_idx] : pair;
  end
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and status/handshake outputs.
  always_comb begin
    state_nx = state;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    o_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        o_busy  = 1'b1;
        o_ready = (!o_valid || i_ready) && (in_cnt < IW'(NPIX));
        if (accept && last_out) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        o_done   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Raster counters, output count and the single-entry output register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col     <= '0;
      row     <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (state == IDLE && i_start) begin
      col     <= '0;
      row     <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      o_valid <= 1'b0;
    end else begin
      if (xfer) begin
        in_cnt <= in_cnt + 1'b1;
        if (col == CW'(MAP_WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(MAP_HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // Producing is only possible when the register is empty or draining,
      // so a load never overwrites an unaccepted pixel.
      if (produce) begin
        o_valid <= 1'b1;
        o_data  <= pooled;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      if (accept) begin
        out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  // Horizontal hold register and line buffer; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (xfer && !col[0]) begin
      h <= pix;
    end
    if (xfer && col[0] && !row[0]) begin
      line_buf[lb_idx] <= pair;
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Self-checking bench for relu_maxpool: directed maps with literal results,
// backpressure, mid-map reset, and randomized maps against a window model.
module tb_relu_maxpool;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int SH = 4;
  localparam int NP = W * H;
  localparam int NO = NP / 4;

  typedef int map_t[NP];
  typedef int pool_t[NO];

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic          ready = 1'b1;
  logic [AW-1:0] data  = '0;
  logic          oready;
  logic          ovalid;
  logic [DW-1:0] odata;
  logic          busy;
  logic          done;

  int     errors = 0;
  int     checks = 0;
  int     expq[$];
  int     got[$];
  int     outs_left = 0;
  bit     final_pending = 1'b0;
  int     done_cnt = 0;
  int     stall_cycles = 0;
  bit     chk_en = 1'b0;
  int     rdy_mode = 0;
  int     stall_left = 0;
  bit     stall_armed = 1'b0;
  logic [DW-1:0] held = '0;
  bit     held_v = 1'b0;

  relu_maxpool #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .MAP_WIDTH (W),
    .MAP_HEIGHT(H),
    .SHIFT     (SH)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_valid(valid),
    .o_ready(oready),
    .i_data (data),
    .o_valid(ovalid),
    .i_ready(ready),
    .o_data (odata),
    .o_busy (busy),
    .o_done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int requant(input int v);
    int q;
    q = v >>> SH;
    if (q < 0) return 0;
    if (q > 255) return 255;
    return q;
  endfunction

  // Reference: pool each 2x2 window of requantized pixels directly.
  task automatic model(input map_t v, output pool_t o);
    int a, b, c, d, m;
    for (int pr = 0; pr < H / 2; pr++) begin
      for (int pc = 0; pc < W / 2; pc++) begin
        a = requant(v[(2 * pr) * W + 2 * pc]);
        b = requant(v[(2 * pr) * W + 2 * pc + 1]);
        c = requant(v[(2 * pr + 1) * W + 2 * pc]);
        d = requant(v[(2 * pr + 1) * W + 2 * pc + 1]);
`ifdef POOL_AVG_EN
        m = (a + b + c + d) / 4;
`else
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
`endif
        o[pr * (W / 2) + pc] = m;
      end
    end
  endtask

  function automatic int rand_val();
    logic [AW-1:0] r;
    r = AW'($urandom);
    case ($urandom_range(0, 4))
      0: return int'($urandom_range(0, 4200));
      1: return -int'($urandom_range(0, 6000));
      2: return int'($urandom_range(4000, 4200));
      3: return int'($signed(r));
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Present one input and wait for it to be accepted (bounded).
  task automatic send_one(input int v, input bit rnd, output int n);
    bit hs;
    valid = 1'b1;
    data  = AW'(v);
    if (rnd) start = 1'($urandom_range(0, 1));
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = oready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no o_ready in %0d cycles expected acceptance", n);
    end
  endtask

  task automatic run_map(input map_t v, input bit rnd, output int cyc);
    pool_t e;
    int d0, n;
    model(v, e);
    foreach (e[i]) expq.push_back(e[i]);
    outs_left = NO;
    got.delete();
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    for (int i = 0; i < NP; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        valid = 1'b0;
        data  = AW'($urandom);
        start = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send_one(v[i], rnd, n);
      cyc += n;
    end
    valid = 1'b0;
    start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("done_count", done_cnt - d0, 1);
    chk("expq_drained", expq.size(), 0);
  endtask

  task automatic check_got(input string name, input pool_t lit);
    chk({name, "_count"}, got.size(), NO);
    for (int i = 0; i < NO; i++) begin
      if (i < got.size()) chk(name, got[i], lit[i]);
    end
  endtask

  // Downstream ready: constant, random, or a 5-cycle stall at the first o_valid.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (stall_left > 0) begin
          stall_left--;
          ready = (stall_left == 0);
        end else if (!stall_armed && ovalid) begin
          stall_armed = 1'b1;
          stall_left  = 5;
          ready       = 1'b0;
        end else begin
          ready = 1'b1;
        end
      end
      default: ready = 1'b1;
    endcase
  end

  // Per-cycle compare of outputs against the model queue and pulse timing.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("o_done", done, final_pending);
      final_pending = 1'b0;
      if (done) begin
        chk("busy_at_done", busy, 0);
        done_cnt++;
      end
      if (!busy) chk("ready_idle", oready, 0);
      if (ovalid && ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got %0d expected no output", odata);
        end else begin
          chk("o_data", odata, expq.pop_front());
        end
        got.push_back(int'(odata));
        outs_left--;
        if (outs_left == 0) final_pending = 1'b1;
        held_v = 1'b0;
      end else if (ovalid) begin
        stall_cycles++;
        chk("ready_in_stall", oready, 0);
        if (held_v) chk("stall_hold", odata, held);
        held   = odata;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    map_t  ramp, relu, sat, b4080, rv;
    pool_t lit, zeros, fulls, mo;
    int    cyc, n;
    for (int i = 0; i < NP; i++) begin
      ramp[i]  = i * 16;
      relu[i]  = -32;
      sat[i]   = 32'h7FFFF;
      b4080[i] = 4080;
    end
`ifdef POOL_AVG_EN
    lit = '{2, 4, 10, 12};
`else
    lit = '{5, 7, 13, 15};
`endif
    zeros = '{0, 0, 0, 0};
    fulls = '{255, 255, 255, 255};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ovalid, 0);
    chk("rst_data", odata, 0);
    chk("rst_ready", oready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model against hand-computed values.
    chk("model_q4080", requant(4080), 255);
    chk("model_q4079", requant(4079), 254);
    chk("model_q4096", requant(4096), 255);
    chk("model_qneg1", requant(-1), 0);
    model(ramp, mo);
    for (int i = 0; i < NO; i++) chk("model_ramp", mo[i], lit[i]);
    model(sat, mo);
    chk("model_sat", mo[0], 255);

    // Ramp with no backpressure: one input per cycle, no bubbles.
    rdy_mode = 0;
    run_map(ramp, 1'b0, cyc);
    check_got("ramp", lit);
    chk("ramp_cycles", cyc, NP);

    run_map(relu, 1'b0, cyc);
    check_got("relu", zeros);
    run_map(sat, 1'b0, cyc);
    check_got("sat", fulls);
    run_map(b4080, 1'b0, cyc);
    check_got("q255", fulls);

    // Backpressure: 5-cycle stall at the first output.
    stall_armed  = 1'b0;
    stall_left   = 0;
    stall_cycles = 0;
    rdy_mode     = 2;
    run_map(ramp, 1'b0, cyc);
    rdy_mode = 0;
    check_got("bp", lit);
    chk("bp_stall_cycles", stall_cycles, 5);

    // Reset mid-map after 6 transfers.
    expq.delete();
    outs_left = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) send_one(ramp[i], 1'b0, n);
    valid = 1'b0;
    chk("latency_valid", ovalid, 1);
    chk("latency_data", odata, lit[0]);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", ovalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", oready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_data", odata, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_map(ramp, 1'b0, cyc);
    check_got("after_rst", lit);

    // Randomized maps with random gaps, random ready and stray i_start.
    rdy_mode = 1;
    for (int m = 0; m < 25; m++) begin
      for (int i = 0; i < NP; i++) rv[i] = rand_val();
      run_map(rv, 1'b1, cyc);
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Post-convolution output stage. Consumes the raster-ordered stream of signed convolution accumulator results, requantizes each by an arithmetic right shift, applies ReLU with unsigned saturation, and performs 2x2 stride-2 max pooling using a half-width line buffer. Pooled bytes are emitted on a valid/ready stream toward the feature-map SRAM writer.

## Interface
- DATA_WIDTH, 8: width of the pooled output pixel (unsigned).
- ACC_WIDTH, 20: width of the signed input accumulator value.
- MAP_WIDTH, 8: input feature-map columns; even, at least 2.
- MAP_HEIGHT, 8: input feature-map rows; even, at least 2.
- SHIFT, 4: requantization right-shift amount, 0 to ACC_WIDTH-1.
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  begin one feature map; sampled only in IDLE.
- i_valid  input  1  i_data valid.
- o_ready  output  1  stage accepts i_data this cycle.
- i_data  input  ACC_WIDTH  signed convolution result, raster order (row-major).
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream accepts o_data.
- o_data  output  DATA_WIDTH  pooled pixel.
- o_busy  output  1  high in RUN.
- o_done  output  1  one-cycle pulse when the map completes.

## Operation
- States: IDLE, RUN, DONE. IDLE with i_start goes to RUN and clears the row/column counters, output count, and o_valid. RUN goes to DONE on the cycle the last pooled pixel, number (MAP_HEIGHT/2)*(MAP_WIDTH/2), is accepted downstream. DONE asserts o_done and returns to IDLE the next cycle. i_start is ignored outside IDLE.
- Input transfer: i_valid && o_ready. o_ready = (state==RUN) && (!o_valid || i_ready) && (input count < MAP_WIDTH*MAP_HEIGHT).
- Requantize: q = i_data >>> SHIFT (arithmetic). If q < 0, p = 0. If q > 2^DATA_WIDTH-1, p = 2^DATA_WIDTH-1. Otherwise p = q[DATA_WIDTH-1:0].
- Pooling, with column c and row r:
  - Even c: hold p in a horizontal register h.
  - Odd c: m = max(h, p).
  - Even r: line_buf[c/2] <= m.
  - Odd r: emit max(line_buf[c/2], m).
- line_buf has MAP_WIDTH/2 entries of DATA_WIDTH bits. Column counter wraps at MAP_WIDTH-1 to 0 and increments the row.
- Output register: single entry. o_valid clears when i_ready is high and no new pixel is produced. A simultaneous drain and produce loads the new pixel with o_valid staying high. o_data holds stable while o_valid && !i_ready.
- Reset values (any time, including mid-map): state IDLE, counters 0, o_valid 0, o_data 0, o_ready 0, o_busy 0, o_done 0. line_buf contents are don't-care.

## Timing
- Latency: the input transfer completing a 2x2 window at edge N gives o_valid high after edge N, visible in cycle N+1.
- Throughput: one input per cycle while i_ready is held high. No bubbles at row wrap.
- o_done rises on the cycle after the final output handshake, lasts 1 cycle. o_busy falls in that same cycle.
- Input transfers with i_valid high outside RUN do not occur, because o_ready is 0 there.

## Configuration
- POOL_AVG_EN defined: average pooling replaces max pooling.
  - Odd c computes the pair sum s = h + p (DATA_WIDTH+1 bits).
  - line_buf widens to DATA_WIDTH+1 bits.
  - Odd r emits (line_buf[c/2] + s) >> 2, truncated (floor).
  - ReLU and saturation are unchanged.
- POOL_AVG_EN undefined: max pooling as in Operation.

## Test plan
All scenarios use MAP_WIDTH=4, MAP_HEIGHT=4, SHIFT=4, ACC_WIDTH=20, DATA_WIDTH=8, i_ready=1 unless stated.
- Ramp: i_start, then inputs k*16 for k=0..15 with i_valid high every cycle -> o_data 5, 7, 13, 15. o_done pulses once, one cycle after the fourth output handshake.
- ReLU: all 16 inputs equal -32 -> four outputs of 0.
- Saturation: all inputs 0x7FFFF -> q=32767 -> four outputs of 255. Input 4080 gives q=255 -> 255, not clipped further.
- Backpressure: ramp with i_ready=0 from first o_valid for 5 cycles -> o_data stays 5 and o_ready stays 0 during the stall. After release, outputs are 5, 7, 13, 15 with none lost or duplicated.
- Reset mid-map: assert i_rst after 6 input transfers -> o_valid, o_busy, o_ready, o_done read 0 immediately. A following i_start plus the full ramp gives 5, 7, 13, 15.
- POOL_AVG_EN build, ramp -> o_data 2, 4, 10, 12.
